traffic_phase_seq: RTL and testbench

Parametrised traffic-light phase sequencer for a two-road intersection (NS/EW), successor to the fixed-width controller core. It adds runtime-programmable durations through a register write port, optional per-road protected left-turn phases selected by a 2-bit rule code, an all-red clearance phase, graceful start/stop, a freeze input and a buzzer cue. All logic runs in one clock domain and advances on a one-cycle tick enable from the existing frequency divider.

---
 rtl/traffic_phase_seq_pkg.sv | 79 +++++++
 rtl/traffic_phase_seq_phase_timer.sv | 55 +++++
 rtl/traffic_phase_seq.sv | 186 ++++++++++++++++++
 tb/tb_traffic_phase_seq.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_phase_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_phase_seq_pkg
// Description : Shared encodings for the traffic phase sequencer: phase
//               codes, duration register addresses, buzzer cue codes,
//               left-turn rule codes and the lamp decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_phase_seq_pkg;

    typedef enum logic [3:0] {
        ST_ALL_R = 4'd0,
        ST_NS_G  = 4'd1,
        ST_NS_Y  = 4'd2,
        ST_NS_L  = 4'd3,
        ST_NS_LY = 4'd4,
        ST_EW_G  = 4'd5,
        ST_EW_Y  = 4'd6,
        ST_EW_L  = 4'd7,
        ST_EW_LY = 4'd8
    } phase_e;

    // Duration register addresses on the write port
    localparam logic [1:0] C_ADDR_G  = 2'd0;
    localparam logic [1:0] C_ADDR_Y  = 2'd1;
    localparam logic [1:0] C_ADDR_L  = 2'd2;
    localparam logic [1:0] C_ADDR_AR = 2'd3;

    // Buzzer cue codes
    localparam logic [1:0] C_RING_OFF  = 2'b00;
    localparam logic [1:0] C_RING_SLOW = 2'b01;
    localparam logic [1:0] C_RING_FAST = 2'b10;

    // Left-turn rule codes
    localparam logic [1:0] C_RULES_NONE = 2'b00;
    localparam logic [1:0] C_RULES_NS   = 2'b01;
    localparam logic [1:0] C_RULES_EW   = 2'b10;
    localparam logic [1:0] C_RULES_BOTH = 2'b11;

    typedef struct packed {
        logic ns_g;
        logic ns_y;
        logic ns_r;
        logic ns_l;
        logic ew_g;
        logic ew_y;
        logic ew_r;
        logic ew_l;
    } lamps_t;

    function automatic logic is_green(input phase_e s);
        return (s == ST_NS_G) || (s == ST_EW_G);
    endfunction

    function automatic logic is_yellow(input phase_e s);
        return (s == ST_NS_Y) || (s == ST_NS_LY) || (s == ST_EW_Y) || (s == ST_EW_LY);
    endfunction

    // Red is the safe default; only the active road's lamp leaves it.
    // During a protected left the straight aspect stays red.
    function automatic lamps_t decode_lamps(input phase_e s);
        lamps_t l;
        l      = '0;
        l.ns_r = 1'b1;
        l.ew_r = 1'b1;
        case (s)
            ST_NS_G:            begin l.ns_g = 1'b1; l.ns_r = 1'b0; end
            ST_NS_Y, ST_NS_LY:  begin l.ns_y = 1'b1; l.ns_r = 1'b0; end
            ST_NS_L:            l.ns_l = 1'b1;
            ST_EW_G:            begin l.ew_g = 1'b1; l.ew_r = 1'b0; end
            ST_EW_Y, ST_EW_LY:  begin l.ew_y = 1'b1; l.ew_r = 1'b0; end
            ST_EW_L:            l.ew_l = 1'b1;
            default:            ;
        endcase
        return l;
    endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_phase_seq_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : traffic_phase_seq_phase_timer
// Description : Phase countdown. Loads a duration (0 treated as 1),
//               decrements, can be cleared or overwritten, otherwise holds.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_phase_seq_phase_timer #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    input  logic             clear,
    input  logic             set,
    input  logic [CNT_W-1:0] set_val,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_nxt,
    output logic             last
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear beats load beats overwrite beats decrement
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = (load_val == '0) ? CNT_W'(1) : load_val;
        end else if (set) begin
            count_d = set_val;
        end else if (dec) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Countdown register
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count     = count_q;
    assign count_nxt = count_d;
    assign last      = (count_q <= CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/traffic_phase_seq.sv
`default_nettype none
// ============================================================================
// Module      : traffic_phase_seq
// Description : Two-road traffic phase sequencer with programmable
//               durations, optional protected lefts, all-red clearance,
//               graceful park, freeze and buzzer cue.
//               Optional feature macro: PED_REQ_EN (pedestrian shortening
//               of green phases).
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_phase_seq
    import traffic_phase_seq_pkg::*;
#(
    parameter int CNT_W   = 6,
    parameter int DEF_G   = 30,
    parameter int DEF_Y   = 3,
    parameter int DEF_L   = 10,
    parameter int DEF_AR  = 2,
    parameter int WARN_T  = 3,
    parameter int PED_CUT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       rules,
    input  logic             wr_en,
    input  logic [1:0]       wr_addr,
    input  logic [CNT_W-1:0] wr_data,
    input  logic             ped_req,
    output logic             ns_g,
    output logic             ns_y,
    output logic             ns_r,
    output logic             ns_l,
    output logic             ew_g,
    output logic             ew_y,
    output logic             ew_r,
    output logic             ew_l,
    output logic [CNT_W-1:0] count,
    output logic [3:0]       phase,
    output logic [1:0]       ring
);

    localparam logic [CNT_W-1:0] C_WARN_T  = CNT_W'(WARN_T);
    localparam logic [CNT_W-1:0] C_PED_CUT = CNT_W'(PED_CUT);

    phase_e                  state_q, state_d;
    logic                    side_q, side_d;     // 0: NS next, 1: EW next
    logic [3:0][CNT_W-1:0]   dur_q, dur_d;
    lamps_t                  lamps_q, lamps_d;
    logic [1:0]              ring_q, ring_d;
    logic [1:0]              left_en;            // bit0 NS, bit1 EW
    logic [1:0]              load_sel;
    logic                    t_load, t_dec, t_clear, t_set, t_last;
    logic [CNT_W-1:0]        count_nxt;
    logic                    ped_hit;

`ifdef PED_REQ_EN
    // A pedestrian request cuts a long green down to the crossing remainder
    assign ped_hit = ped_req && !stop && is_green(state_q) && (count > C_PED_CUT);
`else
    logic unused_ped;
    assign unused_ped = ped_req;
    assign ped_hit    = 1'b0;
`endif

    // Which roads get a protected left after their yellow
    always_comb begin
        left_en = 2'b00;
        case (rules)
            C_RULES_NONE: left_en = 2'b00;
            C_RULES_NS:   left_en = 2'b01;
            C_RULES_EW:   left_en = 2'b10;
            C_RULES_BOTH: left_en = 2'b11;
        endcase
    end

    // Next phase and countdown control; a transition happens on the tick
    // that finds the count at 1 (or 0 when parked)
    always_comb begin
        state_d  = state_q;
        side_d   = side_q;
        t_load   = 1'b0;
        t_dec    = 1'b0;
        t_clear  = 1'b0;
        t_set    = ped_hit;
        load_sel = C_ADDR_G;
        if (!ped_hit && tick && !stop) begin
            if (!t_last) begin
                t_dec = 1'b1;
            end else begin
                t_load = 1'b1;
                unique case (state_q)
                    ST_ALL_R: begin
                        if (start) begin
                            state_d  = side_q ? ST_EW_G : ST_NS_G;
                            side_d   = ~side_q;
                            load_sel = C_ADDR_G;
                        end else begin
                            // Parked: hold all-red with an empty count
                            t_load  = 1'b0;
                            t_clear = 1'b1;
                        end
                    end
                    ST_NS_G:  begin state_d = ST_NS_Y;  load_sel = C_ADDR_Y;  end
                    ST_NS_Y: begin
                        if (left_en[0]) begin state_d = ST_NS_L;  load_sel = C_ADDR_L;  end
                        else            begin state_d = ST_ALL_R; load_sel = C_ADDR_AR; end
                    end
                    ST_NS_L:  begin state_d = ST_NS_LY; load_sel = C_ADDR_Y;  end
                    ST_NS_LY: begin state_d = ST_ALL_R; load_sel = C_ADDR_AR; end
                    ST_EW_G:  begin state_d = ST_EW_Y;  load_sel = C_ADDR_Y;  end
                    ST_EW_Y: begin
                        if (left_en[1]) begin state_d = ST_EW_L;  load_sel = C_ADDR_L;  end
                        else            begin state_d = ST_ALL_R; load_sel = C_ADDR_AR; end
                    end
                    ST_EW_L:  begin state_d = ST_EW_LY; load_sel = C_ADDR_Y;  end
                    ST_EW_LY: begin state_d = ST_ALL_R; load_sel = C_ADDR_AR; end
                    default:  begin state_d = ST_ALL_R; load_sel = C_ADDR_AR; end
                endcase
            end
        end
    end

    // Duration register write port; a same-edge load still sees the old value
    always_comb begin
        dur_d = dur_q;
        if (wr_en) begin
            dur_d[wr_addr] = wr_data;
        end
    end

    // Lamp and buzzer values for the phase being entered
    always_comb begin
        lamps_d = decode_lamps(state_d);
        ring_d  = C_RING_OFF;
        if (is_green(state_d) && (count_nxt <= C_WARN_T)) begin
            ring_d = C_RING_FAST;
        end else if (is_yellow(state_d)) begin
            ring_d = C_RING_SLOW;
        end
    end

    // State, side, duration and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q            <= ST_ALL_R;
            side_q             <= 1'b0;
            dur_q[C_ADDR_G]    <= CNT_W'(DEF_G);
            dur_q[C_ADDR_Y]    <= CNT_W'(DEF_Y);
            dur_q[C_ADDR_L]    <= CNT_W'(DEF_L);
            dur_q[C_ADDR_AR]   <= CNT_W'(DEF_AR);
            lamps_q            <= decode_lamps(ST_ALL_R);
            ring_q             <= C_RING_OFF;
        end else begin
            state_q <= state_d;
            side_q  <= side_d;
            dur_q   <= dur_d;
            lamps_q <= lamps_d;
            ring_q  <= ring_d;
        end
    end

    traffic_phase_seq_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .load      (t_load),
        .load_val  (dur_q[load_sel]),
        .dec       (t_dec),
        .clear     (t_clear),
        .set       (t_set),
        .set_val   (C_PED_CUT),
        .count     (count),
        .count_nxt (count_nxt),
        .last      (t_last)
    );

    assign {ns_g, ns_y, ns_r, ns_l, ew_g, ew_y, ew_r, ew_l} = lamps_q;
    assign phase = state_q;
    assign ring  = ring_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_phase_seq
// Description : Self-checking bench for traffic_phase_seq. A road/kind
//               reference model predicts phase, count, lamps and cue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_seq;
    import traffic_phase_seq_pkg::*;

    localparam int CNT_W   = 6;
    localparam int DEF_G   = 30;
    localparam int DEF_Y   = 3;
    localparam int DEF_L   = 10;
    localparam int DEF_AR  = 2;
    localparam int WARN_T  = 3;
    localparam int PED_CUT = 5;

    // Phase kinds of the reference model
    localparam int K_G = 0, K_Y = 1, K_L = 2, K_LY = 3, K_AR = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             tick = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [1:0]       rules = 2'b00;
    logic             wr_en = 1'b0;
    logic [1:0]       wr_addr = 2'b00;
    logic [CNT_W-1:0] wr_data = '0;
    logic             ped_req = 1'b0;
    logic             ns_g, ns_y, ns_r, ns_l, ew_g, ew_y, ew_r, ew_l;
    logic [CNT_W-1:0] count;
    logic [3:0]       phase;
    logic [1:0]       ring;

    traffic_phase_seq #(
        .CNT_W(CNT_W), .DEF_G(DEF_G), .DEF_Y(DEF_Y), .DEF_L(DEF_L),
        .DEF_AR(DEF_AR), .WARN_T(WARN_T), .PED_CUT(PED_CUT)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .stop(stop),
        .rules(rules), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ped_req(ped_req),
        .ns_g(ns_g), .ns_y(ns_y), .ns_r(ns_r), .ns_l(ns_l),
        .ew_g(ew_g), .ew_y(ew_y), .ew_r(ew_r), .ew_l(ew_l),
        .count(count), .phase(phase), .ring(ring)
    );

    always #5 clk = ~clk;

    // Reference model state
    int m_road = 0;        // road of the current phase, 0 NS / 1 EW
    int m_next_road = 0;   // road served after the next clearance
    int m_kind = K_AR;
    int m_cnt = 0;
    int m_dur [4] = '{DEF_G, DEF_Y, DEF_L, DEF_AR};
    bit rand_tick = 1'b0;

    int n_checks = 0;
    int n_pass = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int dur_of(input int kind);
        int d;
        case (kind)
            K_G:        d = m_dur[0];
            K_Y, K_LY:  d = m_dur[1];
            K_L:        d = m_dur[2];
            default:    d = m_dur[3];
        endcase
        return (d == 0) ? 1 : d;
    endfunction

    function automatic int exp_phase();
        phase_e tbl [2][4];
        tbl = '{'{ST_NS_G, ST_NS_Y, ST_NS_L, ST_NS_LY},
                '{ST_EW_G, ST_EW_Y, ST_EW_L, ST_EW_LY}};
        if (m_kind == K_AR) return int'(ST_ALL_R);
        return int'(tbl[m_road][m_kind]);
    endfunction

    function automatic logic [7:0] exp_lamps();
        logic [3:0] side [2];
        bit act;
        for (int r = 0; r < 2; r++) begin
            act = (m_kind != K_AR) && (m_road == r);
            side[r] = {act && (m_kind == K_G),
                       act && (m_kind == K_Y || m_kind == K_LY),
                       !act || (m_kind == K_L),
                       act && (m_kind == K_L)};
        end
        return {side[0], side[1]};
    endfunction

    function automatic int exp_ring();
        if (m_kind == K_G && m_cnt <= WARN_T) return 2;
        if (m_kind == K_Y || m_kind == K_LY) return 1;
        return 0;
    endfunction

    // Behaviour of one clock edge, from the rules of operation
    task automatic model_edge();
        bit ped;
        if (!reset) begin
            m_road = 0; m_next_road = 0; m_kind = K_AR; m_cnt = 0;
            m_dur = '{DEF_G, DEF_Y, DEF_L, DEF_AR};
            return;
        end
        ped = 1'b0;
`ifdef PED_REQ_EN
        ped = ped_req && !stop && (m_kind == K_G) && (m_cnt > PED_CUT);
`endif
        if (ped) begin
            m_cnt = PED_CUT;
        end else if (tick && !stop) begin
            if (m_cnt > 1) begin
                m_cnt--;
            end else if (m_kind == K_AR && !start) begin
                m_cnt = 0;
            end else begin
                case (m_kind)
                    K_AR: begin m_road = m_next_road; m_next_road = 1 - m_next_road; m_kind = K_G; end
                    K_G:  m_kind = K_Y;
                    K_Y:  m_kind = rules[m_road] ? K_L : K_AR;
                    K_L:  m_kind = K_LY;
                    default: m_kind = K_AR;
                endcase
                m_cnt = dur_of(m_kind);
            end
        end
        if (wr_en) m_dur[wr_addr] = int'(wr_data);
    endtask

    task automatic cycle();
        if (rand_tick) tick = ($urandom_range(0, 3) != 0);
        @(posedge clk);
        model_edge();
        #1;
        chk("phase", 32'(phase), exp_phase());
        chk("count", 32'(count), m_cnt);
        chk("lamps", 32'({ns_g, ns_y, ns_r, ns_l, ew_g, ew_y, ew_r, ew_l}), 32'(exp_lamps()));
        chk("ring", 32'(ring), exp_ring());
    endtask

    task automatic run_until(input int kind, input int road, input int cnt, input int max_cyc);
        int n;
        n = 0;
        while (!(m_kind == kind && (kind == K_AR || m_road == road) && m_cnt == cnt) && n < max_cyc) begin
            cycle();
            n++;
        end
        if (n >= max_cyc) begin
            n_checks++;
            n_fail++;
            $error("FAIL reach: kind %0d road %0d count %0d not reached", kind, road, cnt);
        end
    endtask

    task automatic write_dur(input logic [1:0] addr, input int val);
        wr_en = 1'b1; wr_addr = addr; wr_data = CNT_W'(val);
        cycle();
        wr_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with tick asserted: reset wins
        reset = 1'b0; start = 1'b0; tick = 1'b1;
        cycle(); cycle();
        chk("rst_phase", 32'(phase), int'(ST_ALL_R));
        chk("rst_count", 32'(count), 0);
        chk("rst_lamps", 32'({ns_g, ns_y, ns_r, ns_l, ew_g, ew_y, ew_r, ew_l}), 32'h22);
        chk("rst_ring", 32'(ring), 0);
        reset = 1'b1;
        repeat (3) cycle();

        // Default durations, no lefts, NS first
        start = 1'b1; rules = 2'b00;
        cycle();
        chk("first_g_phase", 32'(phase), int'(ST_NS_G));
        chk("first_g_count", 32'(count), DEF_G);
        rand_tick = 1'b1;
        run_until(K_G, 1, DEF_G, 400);
        rand_tick = 1'b0; tick = 1'b1;

        // Protected lefts on both roads with L = 4
        rules = 2'b11;
        write_dur(C_ADDR_L, 4);
        run_until(K_L, 1, 4, 200);
        chk("ew_l_lamps", 32'({ns_g, ns_y, ns_r, ns_l, ew_g, ew_y, ew_r, ew_l}), 32'h23);
        run_until(K_L, 0, 4, 300);
        chk("ns_l_lamps", 32'({ns_g, ns_y, ns_r, ns_l, ew_g, ew_y, ew_r, ew_l}), 32'h32);
        run_until(K_AR, 0, DEF_AR, 100);
        rules = 2'b00;

        // Zero green treated as one tick, then mid-phase rewrite of green
        reset = 1'b0; start = 1'b0; cycle(); reset = 1'b1;
        write_dur(C_ADDR_G, 0);
        start = 1'b1;
        cycle();
        chk("g0_count", 32'(count), 1);
        cycle();
        chk("g0_next", 32'(phase), int'(ST_NS_Y));
        write_dur(C_ADDR_G, 30);
        run_until(K_G, 0, 20, 500);
        write_dur(C_ADDR_G, 5);
        chk("g_running", 32'(count), 19);
        run_until(K_G, 1, 5, 500);
        repeat (5) cycle();
        chk("g5_len", 32'(phase), int'(ST_EW_Y));

        // Freeze at NS_G count 12
        write_dur(C_ADDR_G, 30);
        run_until(K_G, 0, 12, 500);
        stop = 1'b1;
        repeat (10) cycle();
        chk("stop_count", 32'(count), 12);
        chk("stop_lamps", 32'({ns_g, ns_y, ns_r, ns_l, ew_g, ew_y, ew_r, ew_l}), 32'h82);
        stop = 1'b0;
        cycle();
        chk("stop_resume", 32'(count), 11);

        // Graceful park from EW_Y and restart
        run_until(K_Y, 1, DEF_Y, 500);
        start = 1'b0;
        repeat (7) cycle();
        chk("park_phase", 32'(phase), int'(ST_ALL_R));
        chk("park_count", 32'(count), 0);
        start = 1'b1;
        cycle();
        chk("unpark_phase", 32'(phase), int'(ST_NS_G));
        chk("unpark_count", 32'(count), 30);

`ifdef PED_REQ_EN
        run_until(K_G, 0, 20, 100);
        ped_req = 1'b1; cycle(); ped_req = 1'b0;
        chk("ped_cut", 32'(count), PED_CUT);
        run_until(K_G, 0, 4, 50);
        tick = 1'b0; ped_req = 1'b1; cycle(); ped_req = 1'b0; tick = 1'b1;
        chk("ped_low", 32'(count), 4);
`endif

        // Randomised traffic against the model
        rand_tick = 1'b1;
        for (int i = 0; i < 600; i++) begin
            stop    = ($urandom_range(0, 7) == 0);
            start   = ($urandom_range(0, 15) != 0);
            rules   = 2'($urandom);
            wr_en   = ($urandom_range(0, 9) == 0);
            wr_addr = 2'($urandom);
            wr_data = CNT_W'($urandom_range(0, 7));
            ped_req = ($urandom_range(0, 7) == 0);
            reset   = ($urandom_range(0, 299) != 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
